// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the UART transmit arbiter, its byte-stream requesters
// and the single transmitter core.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 tx_busy;
   logic [ID_W-1:0]      grant_id;
   logic                 grant_active;
   logic                 timeout_err;

   // arbiter side
   modport master (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_start, tx_data, grant_id, grant_active, timeout_err
   );

   // requester / transmitter side
   modport slave (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_start, tx_data, grant_id, grant_active, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// A grant lasts until a last byte, the burst limit, or a handshake timeout.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned TIMEOUT   = 4096
) (
   input logic               hwclk,
   input logic               rst,
   uart_tx_arbiter_if.master bus
);
   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
   localparam int unsigned CNT_W = 8;
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

   typedef enum logic [2:0] {IDLE, FETCH, START, WAIT_ACK, WAIT_DONE} state_t;

   state_t             state;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    grant_id_q;
   logic               grant_active_q;
   logic [NUM_REQ-1:0] req_ready_q;
   logic               tx_start_q;
   logic [7:0]         tx_data_q;
   logic               timeout_err_q;
   logic               last_q;
   logic [CNT_W-1:0]   burst_cnt;
   logic [TMR_W-1:0]   timer;

   logic               pick_found_c;
   logic [ID_W-1:0]    pick_id_c;
   logic [ID_W-1:0]    scan_idx;
   logic [ID_W-1:0]    next_ptr_c;

   // first valid requester at or after rr_ptr, wrapping
   always_comb begin
      pick_found_c = 1'b0;
      pick_id_c    = '0;
      scan_idx     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!pick_found_c && bus.req_valid[scan_idx]) begin
            pick_found_c = 1'b1;
            pick_id_c    = scan_idx;
         end
      end
   end

   assign next_ptr_c = ID_W'((32'(grant_id_q) + 1) % NUM_REQ);

   always_ff @(posedge hwclk) begin
      if (rst) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         grant_id_q     <= '0;
         grant_active_q <= 1'b0;
         req_ready_q    <= '0;
         tx_start_q     <= 1'b0;
         tx_data_q      <= 8'h00;
         timeout_err_q  <= 1'b0;
         last_q         <= 1'b0;
         burst_cnt      <= '0;
         timer          <= '0;
      end else begin
         tx_start_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found_c) begin
                  grant_id_q     <= pick_id_c;
                  grant_active_q <= 1'b1;
                  burst_cnt      <= '0;
                  req_ready_q    <= NUM_REQ'(1) << pick_id_c;
                  timer          <= '0;
                  state          <= FETCH;
               end
            end
            FETCH: begin
               if (bus.req_valid[grant_id_q]) begin
                  tx_data_q   <= bus.req_data[{grant_id_q, 3'b000} +: 8];
                  last_q      <= bus.req_last[grant_id_q];
                  burst_cnt   <= burst_cnt + CNT_W'(1);
                  req_ready_q <= '0;
                  tx_start_q  <= 1'b1;
                  timer       <= '0;
                  state       <= START;
               end else if (timer == TMR_LAST) begin
                  timeout_err_q  <= 1'b1;
                  grant_active_q <= 1'b0;
                  req_ready_q    <= '0;
                  rr_ptr         <= next_ptr_c;
                  timer          <= '0;
                  state          <= IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            START: begin
               timer <= '0;
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (bus.tx_busy) begin
                  timer <= '0;
                  state <= WAIT_DONE;
               end else if (timer == TMR_LAST) begin
                  timeout_err_q  <= 1'b1;
                  grant_active_q <= 1'b0;
                  rr_ptr         <= next_ptr_c;
                  timer          <= '0;
                  state          <= IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            WAIT_DONE: begin
               // no timeout: the transmitter always finishes a frame it started
               if (!bus.tx_busy) begin
                  timer <= '0;
                  if (last_q || burst_cnt == BURST_MAX) begin
                     grant_active_q <= 1'b0;
                     rr_ptr         <= next_ptr_c;
                     state          <= IDLE;
                  end else begin
                     req_ready_q <= NUM_REQ'(1) << grant_id_q;
                     state       <= FETCH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready    = req_ready_q;
   assign bus.tx_start     = tx_start_q;
   assign bus.tx_data      = tx_data_q;
   assign bus.grant_id     = grant_id_q;
   assign bus.grant_active = grant_active_q;
   assign bus.timeout_err  = timeout_err_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmit core between up to NUM_REQ byte-stream requesters. It runs on the board clock and drives the transmitter through a start/busy handshake. A granted requester keeps the transmitter until it marks a byte as last, hits the burst limit, or times out. It sits between application sources (pushbutton message generators, status reporters) and the single transmitter feeding `ftdi_tx`.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 16: maximum bytes per grant before forced release, 1..255.
- TIMEOUT, 4096: cycles allowed for the transmitter to raise busy after `tx_start`. The same limit applies to a granted requester presenting its next byte. Must be ≥2.

- hwclk  in  1  board clock; every register is clocked on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  NUM_REQ  bit i: requester i presents a byte.
- req_data  in  8*NUM_REQ  byte i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  bit i: the presented byte ends requester i's packet.
- req_ready  out  NUM_REQ  one-hot; byte i is accepted in any cycle where req_valid[i] & req_ready[i].
- tx_start  out  1  one-cycle pulse that loads `tx_data` into the transmitter.
- tx_data  out  8  byte to send; held stable from `tx_start` until release or the next load.
- tx_busy  in  1  transmitter is shifting a frame, start through stop bit.
- grant_id  out  $clog2(NUM_REQ)  index of the current owner; valid only while grant_active=1.
- grant_active  out  1  a requester owns the transmitter.
- timeout_err  out  1  one-cycle pulse when a timeout forces a release.

## Operation
- States: IDLE, FETCH, START, WAIT_ACK, WAIT_DONE.
- IDLE
  - If any req_valid bit is set, grant the first set bit found scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - On a grant: set grant_id and grant_active=1, clear burst_cnt, go to FETCH.
  - With no request, stay in IDLE.
- FETCH
  - req_ready[grant_id]=1 combinationally; all other ready bits stay 0.
  - If req_valid[grant_id]=1:
    - capture req_data into tx_data;
    - latch req_last into last_q;
    - burst_cnt++;
    - go to START.
  - Otherwise the timer counts. At TIMEOUT cycles: pulse timeout_err, then release.
- START
  - tx_start=1 for exactly this cycle, then go to WAIT_ACK.
- WAIT_ACK
  - tx_busy=1 moves to WAIT_DONE.
  - Otherwise the timer counts. At TIMEOUT cycles: pulse timeout_err, then release.
- WAIT_DONE
  - Wait while tx_busy=1; there is no timeout here.
  - When tx_busy=0: release if last_q=1 or burst_cnt==MAX_BURST; otherwise return to FETCH.
- Release:
  - grant_active=0;
  - rr_ptr = (grant_id+1) mod NUM_REQ;
  - go to IDLE.
- Timer rules:
  - Width is $clog2(TIMEOUT+1).
  - Cleared on every state entry.
  - Counts only in FETCH and WAIT_ACK.
- burst_cnt is 8 bits wide and never wraps, because release occurs at MAX_BURST.
- Arbitration is not preemptive. Valid bits from other requesters never affect the current grant.
- A requester dropping req_valid inside a packet is not an error until TIMEOUT elapses.
- Reset values, valid in the cycle after rst is sampled high:
  - state=IDLE, rr_ptr=0, grant_id=0, grant_active=0;
  - req_ready=0, tx_start=0, tx_data=8'h00, timeout_err=0;
  - burst_cnt=0, timer=0.
- Reset mid-frame abandons the frame. The transmitter finishes the frame on its own; the arbiter ignores tx_busy until a new grant.

## Timing
- Request to first transfer:
  - cycle 0: req_valid rises while in IDLE;
  - cycle 1: grant_active=1 and req_ready=1 (FETCH);
  - cycle 2: tx_start=1.
- Byte accept to tx_start: exactly 1 cycle.
- Back-to-back bytes in one packet: the next req_ready rises 1 cycle after tx_busy falls.
- After release, IDLE takes 1 cycle; the earliest next grant is 1 cycle after release.
- A new grant and a release never occur in the same cycle.
- req_ready and tx_start are never both 1 in the same cycle.
- timeout_err pulses in the same cycle the release transition is taken.

## Test plan
- Single requester: req 0 sends 3 bytes 0x47,0x4F,0x21 with req_last on 0x21. The model asserts busy 2 cycles after start for 10 cycles.
  - Required: exactly 3 tx_start pulses with tx_data in that order.
  - Required: grant_active falls after the third busy fall, and rr_ptr=1.
- Round-robin fairness: reqs 0, 2 and 3 each hold valid continuously with 1-byte packets (last=1), starting at rr_ptr=0.
  - Required: grant order 0,2,3,0,2,3.
  - Required: req 1 never receives ready.
- Burst limit: MAX_BURST=4, req 1 streams 10 bytes with no last, req 0 also valid.
  - Required: req 1 is released after 4 bytes and req 0 is granted next.
  - Required: req 1 is granted again only after req 0 releases.
- Transmitter timeout: tx_busy held 0, TIMEOUT=8.
  - Required: timeout_err pulses exactly 8 cycles after WAIT_ACK entry, and grant_active falls in that cycle.
  - Required: the next requester is granted 1 cycle later.
- Requester stall: the granted requester drops valid mid-packet for 5 cycles (TIMEOUT=8), then drops it again for 8 cycles.
  - Required: the first stall causes no error and the byte is accepted in cycle 6.
  - Required: the second stall pulses timeout_err and releases the grant.
- Reset mid-operation: assert rst in WAIT_DONE and in FETCH.
  - Required: the next cycle shows all outputs at their reset values with rr_ptr=0.
  - Required: the first post-reset grant goes to the lowest valid index.
